stream_fifo: RTL and testbench

Parametrised synchronous stream FIFO with valid/ready handshakes on both ports, first-word-fall-through output, a full power-of-two capacity, an occupancy count, runtime-programmable almost thresholds, and a synchronous flush. It is the next-generation FIFO for producer/consumer links on the single system clock, such as UART, keyboard and CPU-to-peripheral streams. Unlike the earlier FIFO, the head word is presented before it is consumed, and no storage slot is sacrificed.

---
 rtl/common_pkg.sv | 18 +
 rtl/fifo_ram.sv | 22 ++
 rtl/stream_fifo.sv | 120 ++++++++++++
 tb/tb_stream_fifo.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/common_pkg.sv
// Shared package: FIFO status record registered by peripherals, plus its reset value.
package common;

  typedef struct packed {
    logic empty;
    logic almost_empty;
    logic almost_full;
    logic full;
  } fifo_status_t;

  localparam fifo_status_t FIFO_STATUS_RESET = '{
    empty:        1'b1,
    almost_empty: 1'b1,
    almost_full:  1'b0,
    full:         1'b0
  };

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage for stream_fifo: synchronous write, asynchronous read, no reset.
module fifo_ram #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/stream_fifo.sv
// First-word-fall-through stream FIFO using all 2^ADDR_WIDTH slots, with programmable
// almost flags and flush. Define FIFO_ERROR_FLAGS_EN to enable sticky overflow/underflow flags.
module stream_fifo
  import common::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  flush_i,
  input  logic [DATA_WIDTH-1:0] write_data_i,
  input  logic                  write_valid_i,
  output logic                  write_ready_o,
  output logic [DATA_WIDTH-1:0] read_data_o,
  output logic                  read_valid_o,
  input  logic                  read_ready_i,
  input  logic [ADDR_WIDTH:0]   almost_empty_thresh_i,
  input  logic [ADDR_WIDTH:0]   almost_full_thresh_i,
  output logic [ADDR_WIDTH:0]   count_o,
  output logic                  fifo_empty_o,
  output logic                  fifo_almost_empty_o,
  output logic                  fifo_almost_full_o,
  output logic                  fifo_full_o,
  output logic                  overflow_o,
  output logic                  underflow_o,
  input  logic                  error_clear_i
);

  typedef logic [DATA_WIDTH-1:0] data_t;
  typedef logic [ADDR_WIDTH:0]   ptr_t;
  typedef logic [ADDR_WIDTH:0]   count_t;

  localparam count_t DEPTH_C = count_t'(2**ADDR_WIDTH);

  ptr_t         wr_ptr_p0;
  ptr_t         rd_ptr_p0;
  fifo_status_t status_p0;
  fifo_status_t status_next;
  count_t       count_next;
  data_t        ram_rdata;
  logic         wr_acc;
  logic         rd_acc;

  // The wrap bit lets the pointer difference reach DEPTH, so no slot is sacrificed.
  assign count_o       = wr_ptr_p0 - rd_ptr_p0;
  assign write_ready_o = !status_p0.full;
  assign read_valid_o  = !status_p0.empty;
  assign wr_acc        = write_valid_i && write_ready_o;
  assign rd_acc        = read_valid_o && read_ready_i;

  assign fifo_empty_o        = status_p0.empty;
  assign fifo_almost_empty_o = status_p0.almost_empty;
  assign fifo_almost_full_o  = status_p0.almost_full;
  assign fifo_full_o         = status_p0.full;

  always_comb begin
    count_next = count_o;
    if (wr_acc && !rd_acc)      count_next = count_o + count_t'(1);
    else if (rd_acc && !wr_acc) count_next = count_o - count_t'(1);
    status_next.empty        = (count_next == '0);
    status_next.full         = (count_next == DEPTH_C);
    status_next.almost_empty = (count_next <= almost_empty_thresh_i);
    status_next.almost_full  = (count_next >= almost_full_thresh_i);
  end

  // Stage p0: pointers and status flags; flush returns to the reset state.
  always_ff @(posedge clk_i) begin
    if (reset_i || flush_i) begin
      wr_ptr_p0 <= '0;
      rd_ptr_p0 <= '0;
      status_p0 <= FIFO_STATUS_RESET;
    end else begin
      if (wr_acc) wr_ptr_p0 <= wr_ptr_p0 + ptr_t'(1);
      if (rd_acc) rd_ptr_p0 <= rd_ptr_p0 + ptr_t'(1);
      status_p0 <= status_next;
    end
  end

  fifo_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk   (clk_i),
    .we    (wr_acc && !flush_i && !reset_i),
    .waddr (wr_ptr_p0[ADDR_WIDTH-1:0]),
    .wdata (write_data_i),
    .raddr (rd_ptr_p0[ADDR_WIDTH-1:0]),
    .rdata (ram_rdata)
  );

  // Storage is not reset, so the head word is masked whenever nothing is held.
  assign read_data_o = read_valid_o ? ram_rdata : '0;

`ifdef FIFO_ERROR_FLAGS_EN
  logic overflow_p0;
  logic underflow_p0;

  // A clear coinciding with a new error leaves the flag set.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      overflow_p0  <= 1'b0;
      underflow_p0 <= 1'b0;
    end else begin
      overflow_p0  <= (overflow_p0 && !error_clear_i) || (write_valid_i && !write_ready_o);
      underflow_p0 <= (underflow_p0 && !error_clear_i) ||
                      (read_ready_i && !read_valid_o && !flush_i);
    end
  end

  assign overflow_o  = overflow_p0;
  assign underflow_o = underflow_p0;
`else
  logic unused_error_clear;
  assign unused_error_clear = error_clear_i;
  assign overflow_o         = 1'b0;
  assign underflow_o        = 1'b0;
`endif

endmodule

// File: tb/tb_stream_fifo.sv
// Bench for stream_fifo (DEPTH 4): directed vector table, then randomized traffic against a queue model.
module tb_stream_fifo;
  import common::*;

  localparam int DW = 16;
  localparam int AW = 2;
  localparam int DEPTH = 4;
`ifdef FIFO_ERROR_FLAGS_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0, flush = 1'b0, wv = 1'b0, rr = 1'b0, clr = 1'b0;
  logic [DW-1:0] wd = '0;
  logic [AW:0]   aet = 3'd1, aft = 3'd3;
  logic          wr_rdy, rd_vld;
  logic [DW-1:0] rd;
  logic [AW:0]   count;
  logic          f_empty, f_ae, f_af, f_full, ovf, unf;

  always #5 clk = ~clk;

  stream_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk_i(clk), .reset_i(rst), .flush_i(flush),
    .write_data_i(wd), .write_valid_i(wv), .write_ready_o(wr_rdy),
    .read_data_o(rd), .read_valid_o(rd_vld), .read_ready_i(rr),
    .almost_empty_thresh_i(aet), .almost_full_thresh_i(aft),
    .count_o(count), .fifo_empty_o(f_empty), .fifo_almost_empty_o(f_ae),
    .fifo_almost_full_o(f_af), .fifo_full_o(f_full),
    .overflow_o(ovf), .underflow_o(unf), .error_clear_i(clr)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Reference model: a queue of held words plus the registered flags as the rules define them.
  logic [DW-1:0] mq[$];
  bit m_empty = 1, m_ae = 1, m_af = 0, m_full = 0, m_ovf = 0, m_unf = 0;

  task automatic model_edge();
    bit w_ok, r_ok;
    int n;
    if (rst) begin
      mq.delete();
      {m_empty, m_ae, m_af, m_full, m_ovf, m_unf} = 6'b110000;
    end else begin
      w_ok = !m_full;
      r_ok = !m_empty;
      if (ERR_EN) begin
        m_ovf = (m_ovf && !clr) || (wv && !w_ok);
        m_unf = (m_unf && !clr) || (rr && !r_ok && !flush);
      end
      if (flush) begin
        mq.delete();
        {m_empty, m_ae, m_af, m_full} = 4'b1100;
      end else begin
        if (rr && r_ok) void'(mq.pop_front());
        if (wv && w_ok) mq.push_back(wd);
        n = mq.size();
        m_empty = (n == 0);
        m_full  = (n == DEPTH);
        m_ae    = (n <= int'(aet));
        m_af    = (n >= int'(aft));
      end
    end
  endtask

  task automatic check_model(input string tag);
    logic [DW-1:0] head;
    head = (mq.size() > 0) ? mq[0] : '0;
    check({tag, ".count"}, 32'(count), 32'(mq.size()));
    check({tag, ".rvalid"}, 32'(rd_vld), 32'(mq.size() > 0));
    check({tag, ".rdata"}, 32'(rd), 32'(head));
    check({tag, ".wready"}, 32'(wr_rdy), 32'(!m_full));
    check({tag, ".flags"}, 32'({f_empty, f_ae, f_af, f_full}), 32'({m_empty, m_ae, m_af, m_full}));
    check({tag, ".errs"}, 32'({ovf, unf}), 32'({m_ovf, m_unf}));
  endtask

  task automatic apply(input bit r, input bit f, input bit v, input logic [DW-1:0] d,
                       input bit rdy, input bit c, input logic [AW:0] ae, input logic [AW:0] af);
    rst = r; flush = f; wv = v; wd = d; rr = rdy; clr = c; aet = ae; aft = af;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  typedef struct {
    bit rst, fl, wv;
    logic [DW-1:0] wd;
    bit rr, clr;
    logic [AW:0] aft;
    logic [AW:0] cnt;
    bit rv;
    logic [DW-1:0] rd;
    bit wr;
    logic [3:0] st;
    logic [1:0] err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit r, bit f, bit v, logic [DW-1:0] d, bit rdy, bit c,
                              logic [AW:0] af, logic [AW:0] n, bit rv_e, logic [DW-1:0] rd_e,
                              bit wr_e, logic [3:0] st_e, logic [1:0] err_e);
    vec_t t;
    t.rst = r; t.fl = f; t.wv = v; t.wd = d; t.rr = rdy; t.clr = c; t.aft = af;
    t.cnt = n; t.rv = rv_e; t.rd = rd_e; t.wr = wr_e; t.st = st_e; t.err = err_e;
    return t;
  endfunction

  initial begin
    bit e;
    int wbias, rbias;
    e = ERR_EN;
    // status field order: {empty, almost_empty, almost_full, full}; err order: {overflow, underflow}
    tbl.push_back(mk(1,0,0,16'h0000,0,0,3, 0,0,16'h0000,1,4'b1100,2'b00));
    tbl.push_back(mk(0,0,0,16'h0000,0,0,3, 0,0,16'h0000,1,4'b1100,2'b00));
    tbl.push_back(mk(0,0,1,16'h1111,0,0,3, 1,1,16'h1111,1,4'b0100,2'b00));
    tbl.push_back(mk(0,0,1,16'h2222,0,0,3, 2,1,16'h1111,1,4'b0000,2'b00));
    tbl.push_back(mk(0,0,1,16'h3333,0,0,3, 3,1,16'h1111,1,4'b0010,2'b00));
    tbl.push_back(mk(0,0,1,16'h4444,0,0,3, 4,1,16'h1111,0,4'b0011,2'b00));
    tbl.push_back(mk(0,0,1,16'h5555,1,0,3, 3,1,16'h2222,1,4'b0010,{e,1'b0}));
    tbl.push_back(mk(0,0,0,16'h0000,1,0,3, 2,1,16'h3333,1,4'b0000,{e,1'b0}));
    tbl.push_back(mk(0,0,0,16'h0000,1,0,3, 1,1,16'h4444,1,4'b0100,{e,1'b0}));
    tbl.push_back(mk(0,0,0,16'h0000,1,0,3, 0,0,16'h0000,1,4'b1100,{e,1'b0}));
    tbl.push_back(mk(0,0,1,16'hABCD,1,0,3, 1,1,16'hABCD,1,4'b0100,{e,e}));
    tbl.push_back(mk(0,0,1,16'h1234,1,0,3, 1,1,16'h1234,1,4'b0100,{e,e}));
    tbl.push_back(mk(0,0,0,16'h0000,1,0,3, 0,0,16'h0000,1,4'b1100,{e,e}));
    tbl.push_back(mk(0,0,0,16'h0000,0,1,3, 0,0,16'h0000,1,4'b1100,2'b00));
    tbl.push_back(mk(0,0,1,16'h0A0A,0,0,3, 1,1,16'h0A0A,1,4'b0100,2'b00));
    tbl.push_back(mk(0,0,1,16'h0B0B,0,0,3, 2,1,16'h0A0A,1,4'b0000,2'b00));
    tbl.push_back(mk(0,0,1,16'h0C0C,0,0,3, 3,1,16'h0A0A,1,4'b0010,2'b00));
    tbl.push_back(mk(0,0,0,16'h0000,0,0,4, 3,1,16'h0A0A,1,4'b0000,2'b00));
    tbl.push_back(mk(0,1,1,16'h0D0D,0,0,4, 0,0,16'h0000,1,4'b1100,2'b00));
    tbl.push_back(mk(0,0,0,16'h0000,0,0,4, 0,0,16'h0000,1,4'b1100,2'b00));

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].rst, tbl[i].fl, tbl[i].wv, tbl[i].wd, tbl[i].rr, tbl[i].clr, 3'd1, tbl[i].aft);
      check($sformatf("vec%0d.count", i), 32'(count), 32'(tbl[i].cnt));
      check($sformatf("vec%0d.rvalid", i), 32'(rd_vld), 32'(tbl[i].rv));
      check($sformatf("vec%0d.rdata", i), 32'(rd), 32'(tbl[i].rd));
      check($sformatf("vec%0d.wready", i), 32'(wr_rdy), 32'(tbl[i].wr));
      check($sformatf("vec%0d.flags", i), 32'({f_empty, f_ae, f_af, f_full}), 32'(tbl[i].st));
      check($sformatf("vec%0d.errs", i), 32'({ovf, unf}), 32'(tbl[i].err));
    end

    // Hand sequence: overflow raised at full, then held across a flush until cleared.
    for (int i = 0; i < 5; i++) apply(0, 0, 1, 16'(16'h7000 + i), 0, 0, 3'd1, 3'd3);
    check_model("seq_full");
    apply(0, 1, 0, 16'h0000, 0, 0, 3'd1, 3'd3);
    check_model("seq_flush");
    check("seq_flush.ovf_held", 32'(ovf), 32'(ERR_EN));
    apply(0, 0, 0, 16'h0000, 0, 1, 3'd1, 3'd3);
    check_model("seq_clear");

    // Randomized traffic with occasional flush, reset, clear and threshold changes.
    wbias = 2; rbias = 2;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 150 == 0) begin
        wbias = $urandom_range(1, 3);
        rbias = $urandom_range(1, 3);
      end
      apply($urandom_range(0, 249) == 0,
            $urandom_range(0, 39) == 0,
            $urandom_range(0, 3) < wbias,
            16'($urandom),
            $urandom_range(0, 3) < rbias,
            $urandom_range(0, 29) == 0,
            ($urandom_range(0, 49) == 0) ? 3'($urandom_range(0, 4)) : aet,
            ($urandom_range(0, 49) == 0) ? 3'($urandom_range(0, 4)) : aft);
      check_model($sformatf("rnd%0d", cyc));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
